hp_phase_clkgen: RTL

Parametrised two-phase clock and T-state generator for the HP-35 core family. It replaces the fixed divide-by-8 phi1/phi2 divider with a programmable version: period and phase pulse positions are set at run time, and it adds run, halt and single-step modes for bring-up through the Caravel LA. It sits between `osc_in` and the phi1/phi2 mux feeding the ARC, CTC and ROM instances, and re-aligns its T-state ring from a display-bus resync condition.

---
 rtl/hp_phase_clkgen_pkg.sv | 22 ++
 rtl/hp_phase_clkgen_if.sv | 29 ++
 rtl/hp_phase_clkgen_cfg_shadow.sv | 51 +++++
 rtl/hp_phase_clkgen.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hp_phase_clkgen_pkg.sv
// Shared encodings and reset defaults for the HP two-phase clock generator.
package hp_clk_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_IDLE = 2'b01,
        ST_STEP = 2'b10
    } run_state_e;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_HALT     = 2'b01,
        MODE_STEP     = 2'b10,
        MODE_HALT_ALT = 2'b11
    } mode_e;

    localparam int unsigned HP_DEF_DIV = 7;
    localparam int unsigned HP_DEF_P1  = 5;
    localparam int unsigned HP_DEF_P2  = 7;
    localparam int unsigned HP_MIN_DIV = 3;

endpackage

// File: rtl/hp_phase_clkgen_if.sv
// Control/status bundle between the LA bring-up logic and the clock generator.
interface hp_phase_clkgen_if #(
    parameter int unsigned DIV_W = 4,
    parameter int unsigned N_T   = 4
);
    logic [DIV_W-1:0] div_max;
    logic [DIV_W-1:0] phi1_pos;
    logic [DIV_W-1:0] phi2_pos;
    logic [1:0]       mode;
    logic             step_req;
    logic             resync;
    logic             phi1_n;
    logic             phi2_n;
    logic [N_T-1:0]   t_state;
    logic             wrap;
    logic             step_done;
    logic             cfg_err;
    logic [1:0]       run_state;

    modport master (
        output div_max, phi1_pos, phi2_pos, mode, step_req, resync,
        input  phi1_n, phi2_n, t_state, wrap, step_done, cfg_err, run_state
    );

    modport slave (
        input  div_max, phi1_pos, phi2_pos, mode, step_req, resync,
        output phi1_n, phi2_n, t_state, wrap, step_done, cfg_err, run_state
    );
endinterface

// File: rtl/hp_phase_clkgen_cfg_shadow.sv
// Period/phase config validation and shadow registers, updated only at wrap.
module hp_cfg_shadow
    import hp_clk_pkg::*;
#(
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned DEF_DIV = HP_DEF_DIV,
    parameter int unsigned DEF_P1  = HP_DEF_P1,
    parameter int unsigned DEF_P2  = HP_DEF_P2
) (
    input  logic             osc_in,
    input  logic             cdiv_rst,
    input  logic             wrap,
    input  logic [DIV_W-1:0] div_max,
    input  logic [DIV_W-1:0] phi1_pos,
    input  logic [DIV_W-1:0] phi2_pos,
    output logic [DIV_W-1:0] div_max_s,
    output logic [DIV_W-1:0] p1_s,
    output logic [DIV_W-1:0] p2_s,
    output logic             cfg_err
);

    logic cfg_ok;

    // Reject too-short periods, out-of-range or coincident phase positions.
    always_comb begin
        cfg_ok = 1'b1;
        if (div_max < DIV_W'(HP_MIN_DIV)) cfg_ok = 1'b0;
        if (phi1_pos > div_max)           cfg_ok = 1'b0;
        if (phi2_pos > div_max)           cfg_ok = 1'b0;
        if (phi1_pos == phi2_pos)         cfg_ok = 1'b0;
    end

    // Load a good request at wrap; a bad one keeps the old values and latches the error.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst) begin
            div_max_s <= DIV_W'(DEF_DIV);
            p1_s      <= DIV_W'(DEF_P1);
            p2_s      <= DIV_W'(DEF_P2);
            cfg_err   <= 1'b0;
        end else if (wrap) begin
            if (cfg_ok) begin
                div_max_s <= div_max;
                p1_s      <= phi1_pos;
                p2_s      <= phi2_pos;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hp_phase_clkgen.sv
// Programmable phi1/phi2 generator with T-state ring and run/halt/step control.
module hp_phase_clkgen
    import hp_clk_pkg::*;
#(
    parameter int unsigned DIV_W    = 4,
    parameter int unsigned N_T      = 4,
    parameter int unsigned RESYNC_T = 2,
    parameter int unsigned DEF_DIV  = HP_DEF_DIV,
    parameter int unsigned DEF_P1   = HP_DEF_P1,
    parameter int unsigned DEF_P2   = HP_DEF_P2
) (
    input logic               osc_in,
    input logic               cdiv_rst,
    hp_phase_clkgen_if.slave  bus
);

    localparam logic [N_T-1:0] T_RST      = N_T'(1);
    localparam logic [N_T-1:0] RESYNC_VEC = N_T'(1) << RESYNC_T;

    run_state_e       state_q, state_d;
    mode_e            mode_c;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_max_s, p1_s, p2_s;
    logic [N_T-1:0]   t_state_q;
    logic             advancing, wrap_i;
    logic             phi1r, phi2r;
    logic             step_q, step_pend, step_edge, step_enter;
    logic             step_done_q;

    assign mode_c    = mode_e'(bus.mode);
    assign advancing = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign wrap_i    = advancing && (cnt == div_max_s);
    assign step_edge = bus.step_req && !step_q;

    hp_cfg_shadow #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .DEF_P1  (DEF_P1),
        .DEF_P2  (DEF_P2)
    ) u_cfg (
        .osc_in    (osc_in),
        .cdiv_rst  (cdiv_rst),
        .wrap      (wrap_i),
        .div_max   (bus.div_max),
        .phi1_pos  (bus.phi1_pos),
        .phi2_pos  (bus.phi2_pos),
        .div_max_s (div_max_s),
        .p1_s      (p1_s),
        .p2_s      (p2_s),
        .cfg_err   (bus.cfg_err)
    );

    // Period counter: runs 0..div_max_s while advancing, parked at 0 otherwise.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst)                cnt <= '0;
        else if (!advancing || wrap_i) cnt <= '0;
        else                         cnt <= cnt + 1'b1;
    end

    // Registered phase pulses; distinct compare positions keep them disjoint.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst) begin
            phi1r <= 1'b0;
            phi2r <= 1'b0;
        end else begin
            phi1r <= advancing && (cnt == p1_s);
            phi2r <= advancing && (cnt == p2_s);
        end
    end

    // T-state ring: rotate at wrap, resync overrides the rotation.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst)          t_state_q <= T_RST;
        else if (wrap_i) begin
            if (bus.resync)    t_state_q <= RESYNC_VEC;
            else               t_state_q <= {t_state_q[N_T-2:0], t_state_q[N_T-1]};
        end
    end

    // Step request edge capture; a new edge outranks the clear on STEP entry.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= bus.step_req;
            if (step_edge)       step_pend <= 1'b1;
            else if (step_enter) step_pend <= 1'b0;
        end
    end

    // FSM state and step-complete pulse.
    always_ff @(posedge osc_in or posedge cdiv_rst) begin
        if (cdiv_rst) begin
            state_q     <= ST_RUN;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_done_q <= (state_q == ST_STEP) && wrap_i;
        end
    end

    // Next state: RUN/STEP leave only at wrap so a period is never cut short.
    always_comb begin
        state_d    = state_q;
        step_enter = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (wrap_i && mode_c != MODE_RUN) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (mode_c == MODE_RUN) begin
                    state_d = ST_RUN;
                end else if (mode_c == MODE_STEP && step_pend) begin
                    state_d    = ST_STEP;
                    step_enter = 1'b1;
                end
            end
            ST_STEP: begin
                if (wrap_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.phi1_n    = ~phi1r;
    assign bus.phi2_n    = ~phi2r;
    assign bus.t_state   = t_state_q;
    assign bus.wrap      = wrap_i;
    assign bus.step_done = step_done_q;
    assign bus.run_state = state_q;

endmodule
